// File: rtl/ibus_mem_responder_pkg.sv
// Shared types for the instruction-bus memory responder: request/response structs,
// responder FSM states and the NOP instruction returned for bad fetch addresses.
package ibus_mem_responder_pkg;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } ibus_rsp_state_t;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/ibus_mem_responder_if.sv
// Instruction-bus link between fetch (master) and the memory responder (slave).
interface ibus_mem_responder_if;
   import ibus_mem_responder_pkg::*;

   ibus_req_t  ireq;
   ibus_resp_t iresp;

   modport master (output ireq, input iresp);
   modport slave  (input ireq, output iresp);

endinterface

// File: rtl/ibus_sram.sv
// Word-addressed instruction SRAM: one-cycle synchronous read with enable plus an
// independent write port; a same-cycle read of the written index returns the old word.
module ibus_sram #(
   parameter int MEM_WORDS = 4096
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         rd_en,
   input  logic [$clog2(MEM_WORDS)-1:0] rd_idx,
   output logic [31:0]                  rd_data,
   input  logic                         wr_en,
   input  logic [$clog2(MEM_WORDS)-1:0] wr_idx,
   input  logic [31:0]                  wr_data
);

   logic [31:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Only the read register is cleared by reset; the array keeps its contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

endmodule

// File: rtl/ibus_mem_responder.sv
// Instruction-bus responder backed by a preloadable SRAM with fixed access latency.
// Optional IBUS_RESP_ERR_EN adds an err output flagging bad fetch addresses with data_ok.
module ibus_mem_responder
   import ibus_mem_responder_pkg::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int          LATENCY   = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   ibus_mem_responder_if.slave          bus,
   input  logic                         wr_en,
   input  logic [$clog2(MEM_WORDS)-1:0] wr_idx,
   input  logic [31:0]                  wr_data
`ifdef IBUS_RESP_ERR_EN
   ,
   output logic                         err
`endif
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   ibus_rsp_state_t state_reg;
   logic [3:0]      cnt_reg;
   logic [63:0]     addr_reg;
   logic            data_ok_reg;
   logic            nop_reg;
`ifdef IBUS_RESP_ERR_EN
   logic            err_reg;
`endif

   logic [63:0]     rd_addr;
   logic [61:0]     word_off;
   logic            bad;
   logic            rd_en;
   logic [31:0]     sram_data;

   // In IDLE the read may be issued in the accept cycle (zero latency), so decode the live address.
   assign rd_addr  = (state_reg == IDLE) ? bus.ireq.addr : addr_reg;
   assign word_off = rd_addr[63:2] - BASE_ADDR[63:2];
   assign bad      = (rd_addr < BASE_ADDR) || (word_off >= 62'(MEM_WORDS)) || (rd_addr[1:0] != 2'b00);

   assign rd_en = ((state_reg == IDLE) && bus.ireq.valid && (LATENCY == 0)) ||
                  ((state_reg == WAIT) && (cnt_reg == 4'd1));

   ibus_sram #(
      .MEM_WORDS (MEM_WORDS)
   ) u_sram (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en),
      .rd_idx  (word_off[IDX_W-1:0]),
      .rd_data (sram_data),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         addr_reg    <= '0;
         data_ok_reg <= 1'b0;
         nop_reg     <= 1'b0;
`ifdef IBUS_RESP_ERR_EN
         err_reg     <= 1'b0;
`endif
      end else begin
         data_ok_reg <= 1'b0;
`ifdef IBUS_RESP_ERR_EN
         err_reg     <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (bus.ireq.valid) begin
                  addr_reg  <= bus.ireq.addr;
                  cnt_reg   <= 4'(LATENCY);
                  state_reg <= (LATENCY == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
               if (cnt_reg == 4'd1) begin
                  state_reg <= RESP;
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
         // The response flags are captured alongside the SRAM read so they align with its data.
         if (rd_en) begin
            data_ok_reg <= 1'b1;
            nop_reg     <= bad;
`ifdef IBUS_RESP_ERR_EN
            err_reg     <= bad;
`endif
         end
      end
   end

   assign bus.iresp.addr_ok = reset && (state_reg == IDLE) && bus.ireq.valid;
   assign bus.iresp.data_ok = data_ok_reg;
   assign bus.iresp.data    = nop_reg ? INSTR_NOP : sram_data;

`ifdef IBUS_RESP_ERR_EN
   assign err = err_reg;
`endif

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Directed bench for ibus_mem_responder: one LATENCY=2 and one LATENCY=0 instance
// sharing clock, reset and the preload port.
module tb_ibus_mem_responder;
   import ibus_mem_responder_pkg::*;

   localparam logic [63:0] BASE = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [3:0]  wr_idx;
   logic [31:0] wr_data;
`ifdef IBUS_RESP_ERR_EN
   logic        err_l2;
   logic        err_l0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ibus_mem_responder_if bus_l2 ();
   ibus_mem_responder_if bus_l0 ();

   ibus_mem_responder #(.MEM_WORDS(16), .BASE_ADDR(BASE), .LATENCY(2)) dut_l2 (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_l2),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data)
`ifdef IBUS_RESP_ERR_EN
      ,
      .err     (err_l2)
`endif
   );

   ibus_mem_responder #(.MEM_WORDS(16), .BASE_ADDR(BASE), .LATENCY(0)) dut_l0 (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_l0),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data)
`ifdef IBUS_RESP_ERR_EN
      ,
      .err     (err_l0)
`endif
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Full LATENCY=2 transaction: accept at T, silent T+1..T+2, data_ok at T+3, hold at T+4.
   task automatic txn_l2(input logic [63:0] a, input logic [31:0] d, input logic e);
      cyc();
      bus_l2.ireq = '{valid: 1'b1, addr: a};
      #1;
      chk1("l2 addr_ok at accept", bus_l2.iresp.addr_ok, 1'b1);
      chk1("l2 data_ok at accept", bus_l2.iresp.data_ok, 1'b0);
      for (int i = 1; i <= 2; i++) begin
         cyc();
         #1;
         chk1("l2 addr_ok in wait", bus_l2.iresp.addr_ok, 1'b0);
         chk1("l2 data_ok in wait", bus_l2.iresp.data_ok, 1'b0);
      end
      cyc();
      #1;
      chk1("l2 data_ok at T+3", bus_l2.iresp.data_ok, 1'b1);
      chk1("l2 addr_ok at T+3", bus_l2.iresp.addr_ok, 1'b0);
      chk32("l2 data at T+3", bus_l2.iresp.data, d);
`ifdef IBUS_RESP_ERR_EN
      chk1("l2 err at T+3", err_l2, e);
`else
      if (e) $display("note: err port not built for addr %h", a);
`endif
      bus_l2.ireq.valid = 1'b0;
      cyc();
      #1;
      chk1("l2 data_ok after resp", bus_l2.iresp.data_ok, 1'b0);
      chk32("l2 data held", bus_l2.iresp.data, d);
`ifdef IBUS_RESP_ERR_EN
      chk1("l2 err after resp", err_l2, 1'b0);
`endif
      $display("txn l2 addr=%h data=%h", a, d);
   endtask

   task automatic txn_l0(input logic [63:0] a, input logic [31:0] d);
      cyc();
      bus_l0.ireq = '{valid: 1'b1, addr: a};
      #1;
      chk1("l0 addr_ok at accept", bus_l0.iresp.addr_ok, 1'b1);
      chk1("l0 data_ok at accept", bus_l0.iresp.data_ok, 1'b0);
      cyc();
      #1;
      chk1("l0 data_ok at T+1", bus_l0.iresp.data_ok, 1'b1);
      chk32("l0 data at T+1", bus_l0.iresp.data, d);
      bus_l0.ireq.valid = 1'b0;
      cyc();
      #1;
      chk1("l0 data_ok after resp", bus_l0.iresp.data_ok, 1'b0);
      $display("txn l0 addr=%h data=%h", a, d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  pidx [4];
      logic [31:0] pdat [4];
      pidx = '{4'd0, 4'd1, 4'd2, 4'd15};
      pdat = '{32'hDEAD_BEEF, 32'hCAFE_0001, 32'h1234_5678, 32'h0F0F_0F0F};

      // Reset state, with valid asserted to show addr_ok is held low.
      reset   = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
      bus_l2.ireq = '{valid: 1'b1, addr: BASE};
      bus_l0.ireq = '{valid: 1'b0, addr: BASE};
      #2;
      chk1("reset addr_ok", bus_l2.iresp.addr_ok, 1'b0);
      chk1("reset data_ok", bus_l2.iresp.data_ok, 1'b0);
      chk32("reset data", bus_l2.iresp.data, 32'h0);
`ifdef IBUS_RESP_ERR_EN
      chk1("reset err", err_l2, 1'b0);
`endif
      cyc();
      cyc();
      bus_l2.ireq.valid = 1'b0;
      reset = 1'b1;

      // Preload
      for (int i = 0; i < 4; i++) begin
         cyc();
         wr_en   = 1'b1;
         wr_idx  = pidx[i];
         wr_data = pdat[i];
      end
      cyc();
      wr_en = 1'b0;
      $display("preload done");

      // Basic LATENCY=2 read
      txn_l2(BASE, 32'hDEAD_BEEF, 1'b0);

      // LATENCY=0, valid held high across two back-to-back fetches
      cyc();
      bus_l0.ireq = '{valid: 1'b1, addr: BASE};
      #1;
      chk1("b2b addr_ok first", bus_l0.iresp.addr_ok, 1'b1);
      cyc();
      bus_l0.ireq.addr = BASE + 64'd4;
      #1;
      chk1("b2b data_ok first", bus_l0.iresp.data_ok, 1'b1);
      chk1("b2b addr_ok in resp", bus_l0.iresp.addr_ok, 1'b0);
      chk32("b2b data first", bus_l0.iresp.data, 32'hDEAD_BEEF);
      cyc();
      #1;
      chk1("b2b addr_ok second", bus_l0.iresp.addr_ok, 1'b1);
      chk1("b2b data_ok gap", bus_l0.iresp.data_ok, 1'b0);
      cyc();
      #1;
      chk1("b2b data_ok second", bus_l0.iresp.data_ok, 1'b1);
      chk32("b2b data second", bus_l0.iresp.data, 32'hCAFE_0001);
      bus_l0.ireq.valid = 1'b0;
      cyc();
      #1;
      chk1("b2b data_ok end", bus_l0.iresp.data_ok, 1'b0);
      $display("txn l0 back-to-back words 0,1");

      // Address boundaries
      txn_l2(BASE + 64'd2, INSTR_NOP, 1'b1);
      txn_l2(64'h7FFF_FFFC, INSTR_NOP, 1'b1);
      txn_l2(BASE + 64'd64, INSTR_NOP, 1'b1);
      txn_l2(BASE + 64'd60, 32'h0F0F_0F0F, 1'b0);

      // Address changes while waiting: latched address is served, new one accepted afterwards
      cyc();
      bus_l2.ireq = '{valid: 1'b1, addr: BASE};
      #1;
      chk1("redirect addr_ok", bus_l2.iresp.addr_ok, 1'b1);
      cyc();
      bus_l2.ireq.addr = BASE + 64'd8;
      #1;
      chk1("redirect addr_ok in wait", bus_l2.iresp.addr_ok, 1'b0);
      cyc();
      #1;
      chk1("redirect data_ok in wait", bus_l2.iresp.data_ok, 1'b0);
      cyc();
      #1;
      chk1("redirect data_ok stale", bus_l2.iresp.data_ok, 1'b1);
      chk32("redirect stale data", bus_l2.iresp.data, 32'hDEAD_BEEF);
      cyc();
      #1;
      chk1("redirect next accept", bus_l2.iresp.addr_ok, 1'b1);
      chk1("redirect data_ok idle", bus_l2.iresp.data_ok, 1'b0);
      cyc();
      cyc();
      cyc();
      #1;
      chk1("redirect data_ok new", bus_l2.iresp.data_ok, 1'b1);
      chk32("redirect new data", bus_l2.iresp.data, 32'h1234_5678);
      bus_l2.ireq.valid = 1'b0;
      cyc();
      $display("txn l2 redirect old=%h new=%h", 32'hDEAD_BEEF, 32'h1234_5678);

      // Reset during WAIT (previous data is nonzero, so the clear is observable)
      txn_l2(BASE + 64'd2, INSTR_NOP, 1'b1);
      cyc();
      bus_l2.ireq = '{valid: 1'b1, addr: BASE + 64'd4};
      #1;
      chk1("midreset accept", bus_l2.iresp.addr_ok, 1'b1);
      cyc();
      reset = 1'b0;
      bus_l2.ireq.valid = 1'b0;
      #1;
      chk1("midreset addr_ok", bus_l2.iresp.addr_ok, 1'b0);
      chk1("midreset data_ok", bus_l2.iresp.data_ok, 1'b0);
      chk32("midreset data", bus_l2.iresp.data, 32'h0);
      cyc();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         chk1("postreset no data_ok", bus_l2.iresp.data_ok, 1'b0);
      end
      txn_l2(BASE + 64'd4, 32'hCAFE_0001, 1'b0);

      // Preload write colliding with the read of the same word
      cyc();
      bus_l0.ireq = '{valid: 1'b1, addr: BASE + 64'd4};
      wr_en   = 1'b1;
      wr_idx  = 4'd1;
      wr_data = 32'h1111_2222;
      #1;
      chk1("collide addr_ok", bus_l0.iresp.addr_ok, 1'b1);
      cyc();
      wr_en = 1'b0;
      bus_l0.ireq.valid = 1'b0;
      #1;
      chk1("collide data_ok", bus_l0.iresp.data_ok, 1'b1);
      chk32("collide old data", bus_l0.iresp.data, 32'hCAFE_0001);
      $display("txn l0 collide addr=%h data=%h", BASE + 64'd4, 32'hCAFE_0001);
      txn_l0(BASE + 64'd4, 32'h1111_2222);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
